// File: rtl/scope_capture.sv
// Triggered multi-channel capture engine. Decimated samples of all channels share one
// circular RAM. A frame holding pretrig samples of history is frozen once the trigger fires
// and the post-trigger count expires. Reads are trigger-aligned: logical index pretrig is
// the sample that fired the trigger.
module scope_capture #(
    parameter int unsigned NCH  = 2,
    parameter int unsigned DW   = 12,
    parameter int unsigned AW   = 10,
    parameter int unsigned DECW = 6
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              sample_en_i,
    input  logic [NCH*DW-1:0] ch_data_i,
    input  logic              arm_i,
    input  logic              auto_rearm_i,
    input  logic              hold_i,
    input  logic [2:0]        trig_ch_i,
    input  logic [1:0]        trig_mode_i,
    input  logic [DW-1:0]     trig_level_i,
    input  logic [AW-1:0]     pretrig_i,
    input  logic [DECW-1:0]   decim_i,
    input  logic [AW-1:0]     rd_addr_i,
    output logic [NCH*DW-1:0] rd_data_o,
    output logic [2:0]        state_o,
    output logic              triggered_o,
    output logic              frame_done_o
);
    localparam int unsigned Depth = 2 ** AW;

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StPre      = 3'd1,
        StWaitTrig = 3'd2,
        StPost     = 3'd3,
        StDone     = 3'd4
    } state_e;

    state_e            state_q, state_d;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     trig_addr_q, trig_addr_d;
    logic [AW-1:0]     pre_cnt_q, pre_cnt_d;
    logic [AW-1:0]     post_cnt_q, post_cnt_d;
    logic [AW-1:0]     pretrig_q, pretrig_d;
    logic [DECW-1:0]   dec_cnt_q, dec_cnt_d;
    logic [DECW-1:0]   decim_q, decim_d;
    logic [NCH*DW-1:0] last_q, last_d;
    logic              prev_valid_q, prev_valid_d;
    logic              triggered_q, triggered_d;
    logic              frame_done_q, frame_done_d;
    logic [NCH*DW-1:0] rd_data_q;

    logic [NCH*DW-1:0] mem [Depth];

    logic              tick;
    logic              wr_en;
    logic              fire;
    logic              rise;
    logic              fall;
    logic              ch_ok;
    logic [DW-1:0]     cur_smp;
    logic [DW-1:0]     prev_smp;
    logic [AW-1:0]     rd_phys;

    assign tick  = sample_en_i && !hold_i && (dec_cnt_q == decim_q);
    assign ch_ok = 32'(trig_ch_i) < NCH;
    assign rise  = prev_valid_q && (prev_smp < trig_level_i) && (cur_smp >= trig_level_i);
    assign fall  = prev_valid_q && (prev_smp >= trig_level_i) && (cur_smp < trig_level_i);
    // pretrig is AW bits wide, so it can never exceed DEPTH-1 and needs no clamp.
    assign rd_phys = trig_addr_q - pretrig_q + rd_addr_i;

    // Select the trigger channel from the live input and from the last written word.
    always_comb begin
        cur_smp  = '0;
        prev_smp = '0;
        for (int k = 0; k < NCH; k++) begin
            if (trig_ch_i == 3'(k)) begin
                cur_smp  = ch_data_i[k*DW +: DW];
                prev_smp = last_q[k*DW +: DW];
            end
        end
    end

    // Trigger condition per mode; an out-of-range channel only fires in immediate mode.
    always_comb begin
        fire = 1'b0;
        unique case (trig_mode_i)
            2'b00:   fire = 1'b1;
            2'b01:   fire = ch_ok && rise;
            2'b10:   fire = ch_ok && fall;
            default: fire = ch_ok && (rise || fall);
        endcase
    end

    // Next-state logic: arm (explicit or auto) wins, otherwise hold freezes everything.
    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        trig_addr_d  = trig_addr_q;
        pre_cnt_d    = pre_cnt_q;
        post_cnt_d   = post_cnt_q;
        pretrig_d    = pretrig_q;
        dec_cnt_d    = dec_cnt_q;
        decim_d      = decim_q;
        last_d       = last_q;
        prev_valid_d = prev_valid_q;
        triggered_d  = triggered_q;
        frame_done_d = 1'b0;
        wr_en        = 1'b0;

        // >= also recovers when the count sits above a newly lowered decim.
        if (sample_en_i && !hold_i) begin
            dec_cnt_d = (dec_cnt_q >= decim_q) ? '0 : dec_cnt_q + 1'b1;
        end

        if (arm_i || (state_q == StDone && auto_rearm_i && !hold_i)) begin
            state_d      = StPre;
            pre_cnt_d    = '0;
            prev_valid_d = 1'b0;
            triggered_d  = 1'b0;
            dec_cnt_d    = '0;
            pretrig_d    = pretrig_i;
            decim_d      = decim_i;
        end else if (!hold_i) begin
            wr_en = tick && (state_q == StPre || state_q == StWaitTrig || state_q == StPost);
            if (wr_en) begin
                wr_ptr_d     = wr_ptr_q + 1'b1;
                last_d       = ch_data_i;
                prev_valid_d = 1'b1;
            end
            unique case (state_q)
                StPre: begin
                    if (tick) pre_cnt_d = pre_cnt_q + 1'b1;
                    if (pre_cnt_q == pretrig_q) state_d = StWaitTrig;
                end
                StWaitTrig: begin
                    if (tick && fire) begin
                        trig_addr_d = wr_ptr_q;
                        triggered_d = 1'b1;
                        // DEPTH-1-pretrig is the bitwise complement in AW bits.
                        post_cnt_d  = ~pretrig_q;
                        if (pretrig_q == {AW{1'b1}}) begin
                            state_d      = StDone;
                            frame_done_d = 1'b1;
                        end else begin
                            state_d = StPost;
                        end
                    end
                end
                StPost: begin
                    if (tick) begin
                        post_cnt_d = post_cnt_q - 1'b1;
                        if (post_cnt_q == AW'(1)) begin
                            state_d      = StDone;
                            frame_done_d = 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Control and datapath registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= StIdle;
            wr_ptr_q     <= '0;
            trig_addr_q  <= '0;
            pre_cnt_q    <= '0;
            post_cnt_q   <= '0;
            pretrig_q    <= '0;
            dec_cnt_q    <= '0;
            decim_q      <= '0;
            last_q       <= '0;
            prev_valid_q <= 1'b0;
            triggered_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            trig_addr_q  <= trig_addr_d;
            pre_cnt_q    <= pre_cnt_d;
            post_cnt_q   <= post_cnt_d;
            pretrig_q    <= pretrig_d;
            dec_cnt_q    <= dec_cnt_d;
            decim_q      <= decim_d;
            last_q       <= last_d;
            prev_valid_q <= prev_valid_d;
            triggered_q  <= triggered_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Sample RAM write port, all channels in one word.
    always_ff @(posedge clk_i) begin
        if (wr_en) mem[wr_ptr_q] <= ch_data_i;
    end

    // Registered trigger-aligned read; a same-address write returns the old word.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) rd_data_q <= '0;
        else         rd_data_q <= mem[rd_phys];
    end

    assign rd_data_o    = rd_data_q;
    assign state_o      = state_q;
    assign triggered_o  = triggered_q;
    assign frame_done_o = frame_done_q;

endmodule

// File: tb/tb_scope_capture.sv
// Bench for scope_capture: random captures checked against a behavioural model that keeps a
// log of every written sample; a completed frame must equal the last DEPTH logged samples
// with the trigger sample at index pretrig.
module tb_scope_capture;
    localparam int unsigned NCH   = 2;
    localparam int unsigned DW    = 12;
    localparam int unsigned AW    = 4;
    localparam int unsigned DECW  = 6;
    localparam int          Depth = 16;

    logic              clk;
    logic              rst_n;
    logic              sample_en;
    logic [NCH*DW-1:0] ch_data;
    logic              arm;
    logic              auto_rearm;
    logic              hold;
    logic [2:0]        trig_ch;
    logic [1:0]        trig_mode;
    logic [DW-1:0]     trig_level;
    logic [AW-1:0]     pretrig;
    logic [DECW-1:0]   decim;
    logic [AW-1:0]     rd_addr;
    logic [NCH*DW-1:0] rd_data;
    logic [2:0]        st;
    logic              trg;
    logic              fd;

    scope_capture #(
        .NCH  (NCH),
        .DW   (DW),
        .AW   (AW),
        .DECW (DECW)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .sample_en_i  (sample_en),
        .ch_data_i    (ch_data),
        .arm_i        (arm),
        .auto_rearm_i (auto_rearm),
        .hold_i       (hold),
        .trig_ch_i    (trig_ch),
        .trig_mode_i  (trig_mode),
        .trig_level_i (trig_level),
        .pretrig_i    (pretrig),
        .decim_i      (decim),
        .rd_addr_i    (rd_addr),
        .rd_data_o    (rd_data),
        .state_o      (st),
        .triggered_o  (trg),
        .frame_done_o (fd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: 0 idle, 1 pre, 2 wait, 3 post, 4 done.
    int m_state, m_pre, m_post, m_dec, m_decim, m_p, m_trig_n;
    bit m_trig, m_fd, m_pv;
    int hist[$];
    int ramp[NCH];
    int step[NCH];
    int rb[Depth];

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int chv(input int w, input int k);
        return (w >> (k * DW)) & 'hFFF;
    endfunction

    task automatic model_reset();
        m_state = 0; m_pre = 0; m_post = 0; m_dec = 0; m_decim = 0; m_p = 0; m_trig_n = 0;
        m_trig = 0; m_fd = 0; m_pv = 0;
        hist.delete();
    endtask

    // Advance the model by one clock using the inputs currently driven.
    task automatic model_step();
        bit tick, wr, fire, rise, fall, ok;
        int cur, prv, nd, ch, lvl;
        ch   = int'(trig_ch);
        lvl  = int'(trig_level);
        tick = sample_en && !hold && (m_dec == m_decim);
        nd   = m_dec;
        if (sample_en && !hold) nd = (m_dec >= m_decim) ? 0 : m_dec + 1;
        m_fd = 0;
        if (arm || (m_state == 4 && auto_rearm && !hold)) begin
            m_state = 1; m_pre = 0; m_pv = 0; m_trig = 0; nd = 0;
            m_p = int'(pretrig); m_decim = int'(decim);
        end else if (!hold) begin
            wr   = tick && m_state >= 1 && m_state <= 3;
            ok   = ch < NCH;
            cur  = ok ? chv(int'(ch_data), ch) : 0;
            prv  = (ok && m_pv) ? chv(hist[$], ch) : 0;
            rise = m_pv && prv < lvl && cur >= lvl;
            fall = m_pv && prv >= lvl && cur < lvl;
            case (trig_mode)
                2'd0:    fire = 1;
                2'd1:    fire = ok && rise;
                2'd2:    fire = ok && fall;
                default: fire = ok && (rise || fall);
            endcase
            case (m_state)
                1: begin
                    if (m_pre == m_p) m_state = 2;
                    if (tick) m_pre++;
                end
                2: if (tick && fire) begin
                    m_trig   = 1;
                    m_trig_n = hist.size();
                    m_post   = Depth - 1 - m_p;
                    if (m_post == 0) begin m_state = 4; m_fd = 1; end
                    else m_state = 3;
                end
                3: if (tick) begin
                    m_post--;
                    if (m_post == 0) begin m_state = 4; m_fd = 1; end
                end
                default: ;
            endcase
            if (wr) begin
                hist.push_back(int'(ch_data));
                m_pv = 1;
            end
        end
        m_dec = nd;
    endtask

    // One clock: model, edge, compare, then move the channel ramps at the falling edge.
    task automatic cyc();
        model_step();
        @(posedge clk);
        #1;
        check("state", int'(st), m_state);
        check("triggered", int'(trg), int'(m_trig));
        check("frame_done", int'(fd), int'(m_fd));
        @(negedge clk);
        for (int k = 0; k < NCH; k++) begin
            ramp[k] = (ramp[k] + step[k]) & 'hFFF;
            ch_data[k*DW +: DW] = DW'(ramp[k]);
        end
    endtask

    task automatic readout();
        int tgt;
        hold = 0; arm = 0; auto_rearm = 0;
        for (int i = 0; i < Depth; i++) begin
            rd_addr = AW'(i);
            cyc();
            rb[i] = int'(rd_data);
            tgt = m_trig_n - m_p + i;
            if (tgt >= 0) check("rd_data", int'(rd_data), hist[tgt]);
        end
    endtask

    task automatic run_capture(input int mode, input int ch, input int lvl, input int p,
                               input int dcm, input bit rand_hold, input int budget);
        int hl;
        hl = 0;
        trig_mode = 2'(mode); trig_ch = 3'(ch); trig_level = DW'(lvl);
        pretrig = AW'(p); decim = DECW'(dcm); auto_rearm = 0; hold = 0;
        arm = 1; sample_en = 1'($urandom_range(0, 1));
        cyc();
        arm = 0;
        for (int c = 0; c < budget && m_state != 4; c++) begin
            sample_en = ($urandom_range(0, 9) < 6);
            if (hl > 0) begin hold = 1; hl--; end
            else if (rand_hold && $urandom_range(0, 29) == 0) begin
                hold = 1; hl = $urandom_range(1, 25);
            end else hold = 0;
            arm = ($urandom_range(0, 199) == 0);
            cyc();
            arm = 0;
        end
        hold = 0;
        if (m_state == 4) readout();
    endtask

    int t_trig, t_fd;

    initial begin
        rst_n = 0; sample_en = 0; ch_data = '0; arm = 0; auto_rearm = 0; hold = 0;
        trig_ch = 0; trig_mode = 0; trig_level = 0; pretrig = 0; decim = 0; rd_addr = 0;
        for (int k = 0; k < NCH; k++) begin ramp[k] = 0; step[k] = 0; end
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_state", int'(st), 0);
        check("rst_triggered", int'(trg), 0);
        check("rst_frame_done", int'(fd), 0);
        check("rst_rd_data", int'(rd_data), 0);
        rst_n = 1;
        @(negedge clk);

        // Rising ramp on ch0, pretrig 4, level 0x800.
        ramp[0] = 0; step[0] = 'h100; ramp[1] = 0; step[1] = 37;
        ch_data = '0;
        trig_mode = 2'd1; trig_ch = 0; trig_level = 12'h800; pretrig = 4; decim = 0;
        sample_en = 1;
        arm = 1; cyc(); arm = 0;
        t_trig = -1; t_fd = -1;
        for (int c = 0; c < 200 && m_state != 4; c++) begin
            cyc();
            if (t_trig < 0 && trg) t_trig = c;
            if (fd) t_fd = c;
        end
        check("ramp_post_len", t_fd - t_trig, 11);
        readout();
        check("ramp_trig_sample", int'(chv(rb[4], 0) >= 'h800), 1);
        check("ramp_before_trig", int'(chv(rb[3], 0) < 'h800), 1);

        // Decimation by 4 with a unit ramp: frame samples are 4 apart.
        ramp[0] = 100; step[0] = 1;
        trig_mode = 2'd0; pretrig = 0; decim = 3; sample_en = 1;
        arm = 1; cyc(); arm = 0;
        for (int c = 0; c < 300 && m_state != 4; c++) cyc();
        readout();
        for (int i = 1; i < Depth; i++) begin
            check("decim_spacing", (chv(rb[i], 0) - chv(rb[i-1], 0)) & 'hFFF, 4);
        end

        // Hold for 20 cycles in WAIT_TRIG while the ramp sweeps through the level.
        ramp[0] = 0; step[0] = 'h90;
        trig_mode = 2'd1; trig_ch = 0; trig_level = 12'h800; pretrig = 2; decim = 0;
        sample_en = 1;
        arm = 1; cyc(); arm = 0;
        for (int c = 0; c < 50 && m_state != 2; c++) cyc();
        hold = 1;
        for (int c = 0; c < 20; c++) cyc();
        check("hold_no_trigger", int'(trg), 0);
        check("hold_state", int'(st), 2);
        hold = 0;
        for (int c = 0; c < 200 && m_state != 4; c++) cyc();
        readout();

        // arm on a cycle where immediate mode would fire.
        trig_mode = 2'd0; pretrig = 0; decim = 0; sample_en = 1; step[0] = 5;
        arm = 1; cyc(); arm = 0;
        for (int c = 0; c < 20 && m_state != 2; c++) cyc();
        arm = 1; cyc(); arm = 0;
        check("arm_wins_state", int'(st), 1);
        check("arm_wins_triggered", int'(trg), 0);

        // Asynchronous reset while in POST.
        for (int c = 0; c < 20 && m_state != 3; c++) cyc();
        #2;
        rst_n = 0;
        #1;
        model_reset();
        check("midpost_state", int'(st), 0);
        check("midpost_triggered", int'(trg), 0);
        check("midpost_rd_data", int'(rd_data), 0);
        check("midpost_frame_done", int'(fd), 0);
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);

        // Maximum pretrig: no POST phase at all.
        run_capture(0, 0, 0, Depth - 1, 0, 0, 200);

        // Free-running immediate mode with automatic re-arm.
        trig_mode = 2'd0; pretrig = 0; decim = 0; sample_en = 1; auto_rearm = 1;
        arm = 1; cyc(); arm = 0;
        for (int c = 0; c < 120; c++) cyc();
        auto_rearm = 0;

        // Random captures.
        for (int r = 0; r < 30; r++) begin
            for (int k = 0; k < NCH; k++) step[k] = $urandom_range(0, 400);
            run_capture($urandom_range(0, 3), $urandom_range(0, 2), $urandom_range(0, 4095),
                        $urandom_range(0, Depth - 1), $urandom_range(0, 3), 1, 600);
        end

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
